ccw_sequencer: RTL

CCW_SEQUENCER -- requirements
Module: ccw_sequencer

---
 rtl/ccw_sequencer_pkg.sv | 31 +++
 rtl/ccw_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ccw_sequencer_pkg.sv
// Shared definitions for the channel command word sequencer: state encoding,
// CCW field layout and status bit positions.
package ccw_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_WAIT,
        S_START,
        S_WAIT_ACTIVE,
        S_WAIT_END,
        S_DONE
    } state_t;

    // CCW word layout: [31:24] command, [23:16] flags, [15:8] count, [7:0] reserved
    localparam int CMD_LSB   = 24;
    localparam int FLAGS_LSB = 16;
    localparam int COUNT_LSB = 8;

    localparam int CC_BIT = 7;  // flags: command chain
    localparam int DE_BIT = 5;  // status: device end

    localparam logic [7:0] ERR_MASK_DEFAULT   = 8'h03;
    localparam logic [7:0] LAST_PTR           = 8'hFF;
    localparam int         ACTIVE_WAIT_CYCLES = 4;

    function automatic logic [7:0] ccw_field(input logic [31:0] word, input int lsb);
        return word[lsb +: 8];
    endfunction

endpackage

// File: rtl/ccw_sequencer.sv
// Walks a chain of channel command words from memory, starts each on the
// channel, and reports the final status, residual count and CCW address.
module ccw_sequencer
    import ccw_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  ERR_MASK       = ERR_MASK_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [7:0]  ccw_base,
    input  logic [7:0]  dev_address,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  ch_address,
    output logic [7:0]  ch_command,
    output logic [7:0]  ch_count,
    output logic        ch_start_strobe,
    input  logic        ch_active,
    input  logic [7:0]  ch_status,
    input  logic        ch_status_strobe,
    input  logic [7:0]  ch_res_count,
    output logic        busy,
    output logic        done,
    output logic [7:0]  done_status,
    output logic [7:0]  done_count,
    output logic [7:0]  done_ccw,
    output logic        error
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  ACTIVE_LAST  = 2'(ACTIVE_WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        cc_q, cc_d;
    logic [7:0]  status_q, status_d;
    logic        err_q, err_d;
    logic [7:0]  res_q, res_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  wa_q, wa_d;

    logic        mem_rd_d, strobe_d, busy_d, done_d, error_d;
    logic [7:0]  mem_addr_d, ch_address_d, ch_command_d, ch_count_d;
    logic [7:0]  done_status_d, done_count_d, done_ccw_d;

    logic [7:0]  eff_status;
    logic        eff_err;
    logic        unused_rsvd;

    assign unused_rsvd = ^{mem_rdata[7:0], mem_rdata[FLAGS_LSB +: 7]};

    always_comb begin
        // A status strobe in the same cycle as the active fall must steer the decision.
        eff_status = ch_status_strobe ? ch_status : status_q;
        eff_err    = err_q | (ch_status_strobe & (|(ch_status & ERR_MASK)));

        state_d       = state_q;
        ptr_d         = ptr_q;
        cc_d          = cc_q;
        status_d      = status_q;
        err_d         = err_q;
        res_d         = res_q;
        timer_d       = '0;
        wa_d          = '0;
        mem_addr_d    = mem_addr;
        ch_address_d  = ch_address;
        ch_command_d  = ch_command;
        ch_count_d    = ch_count;
        strobe_d      = 1'b0;
        done_d        = 1'b0;
        done_status_d = done_status;
        done_count_d  = done_count;
        done_ccw_d    = done_ccw;
        error_d       = error;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    ptr_d    = ccw_base;
                    err_d    = 1'b0;
                    status_d = '0;
                    res_d    = '0;
                    error_d  = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                ch_command_d = ccw_field(mem_rdata, CMD_LSB);
                ch_count_d   = ccw_field(mem_rdata, COUNT_LSB);
                cc_d         = mem_rdata[FLAGS_LSB + CC_BIT];
                ch_address_d = dev_address;
                strobe_d     = ~ch_active;
                state_d      = S_START;
            end
            S_START: begin
                // Hold off the start until the channel is idle.
                if (ch_start_strobe) state_d = S_WAIT_ACTIVE;
                else                 strobe_d = ~ch_active;
            end
            S_WAIT_ACTIVE: begin
                if (ch_active) begin
                    state_d = S_WAIT_END;
                end else if (wa_q == ACTIVE_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wa_d = wa_q + 2'd1;
                end
            end
            S_WAIT_END: begin
                if (ch_status_strobe) status_d = ch_status;
                err_d = eff_err;
                if (!ch_active) begin
                    res_d = ch_res_count;
                    if (eff_status[DE_BIT]) begin
                        if (cc_q && !eff_err) begin
                            if (ptr_q != LAST_PTR) begin
                                ptr_d   = ptr_q + 8'd1;
                                state_d = S_FETCH;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        // Only a command-zero program with clean status ends quietly.
                        if (!(ch_command == 8'h00 && eff_status == 8'h00)) err_d = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_rd_d = (state_d == S_FETCH);
        if (state_d == S_FETCH) mem_addr_d = ptr_d;
        busy_d = !(state_d inside {S_IDLE, S_DONE});
        if (state_d == S_DONE) begin
            done_d        = 1'b1;
            done_status_d = status_d;
            done_count_d  = res_d;
            done_ccw_d    = ptr_d;
            error_d       = err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            cc_q            <= 1'b0;
            status_q        <= '0;
            err_q           <= 1'b0;
            res_q           <= '0;
            timer_q         <= '0;
            wa_q            <= '0;
            mem_rd          <= 1'b0;
            mem_addr        <= '0;
            ch_address      <= '0;
            ch_command      <= '0;
            ch_count        <= '0;
            ch_start_strobe <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            done_status     <= '0;
            done_count      <= '0;
            done_ccw        <= '0;
            error           <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cc_q            <= cc_d;
            status_q        <= status_d;
            err_q           <= err_d;
            res_q           <= res_d;
            timer_q         <= timer_d;
            wa_q            <= wa_d;
            mem_rd          <= mem_rd_d;
            mem_addr        <= mem_addr_d;
            ch_address      <= ch_address_d;
            ch_command      <= ch_command_d;
            ch_count        <= ch_count_d;
            ch_start_strobe <= strobe_d;
            busy            <= busy_d;
            done            <= done_d;
            done_status     <= done_status_d;
            done_count      <= done_count_d;
            done_ccw        <= done_ccw_d;
            error           <= error_d;
        end
    end

endmodule
